circle_engine: RTL
==================

// Module: circle_engine
// PURPOSE
//  Parametrised midpoint-circle rasteriser; successor to the fixed five-circle datapath.
//  Accepts one circle per start (centre, radius, colour) over a start/busy handshake.
//  Streams the 8-way symmetric outline pixels to the VGA adaptor through a valid/ready port.
//  Off-screen pixels are clipped; the pixel sink may apply backpressure.
// PARAMETERS
//  X_W       8    width of x coordinate / centre_x
//  Y_W       7    width of y coordinate / centre_y
//  R_W       7    width of radius
//  COLOUR_W  3    width of colour
//  XMAX      159  largest visible x; larger x is clipped
//  YMAX      119  largest visible y; larger y is clipped
// PORTS
//  clock       in   1         rising-edge clock
//  reset       in   1         asynchronous, active-high reset
//  start       in   1         request a new circle; sampled only in IDLE
//  centre_x    in   X_W       centre x (unsigned); latched when start is accepted
//  centre_y    in   Y_W       centre y (unsigned); latched when start is accepted
//  radius      in   R_W       radius (unsigned); latched when start is accepted
//  colour_in   in   COLOUR_W  pixel colour; latched when start is accepted
//  busy        out  1         high from the cycle after acceptance through DONE
//  done        out  1         one-cycle pulse in DONE
//  plot_valid  out  1         x, y, colour hold a visible pixel
//  plot_ready  in   1         sink accepts the pixel when valid && ready
//  x           out  X_W       pixel x
//  y           out  Y_W       pixel y
//  colour      out  COLOUR_W  pixel colour (latched colour_in)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, plot_valid, x, y, colour, ox, oy, crit, oct = 0.
//   Async assert clears the block mid-circle; no further pixels are emitted.
//  FSM states:
//   IDLE: start=1 latches the operands -> INIT. start is ignored in every other state.
//   INIT: 1 cycle; ox=radius, oy=0, crit=1-radius, oct=0 -> PLOT.
//   PLOT: oct 0..7 selects a point:
//    (cx+ox,cy+oy) (cx+oy,cy+ox) (cx-ox,cy+oy) (cx-oy,cy+ox)
//    (cx-ox,cy-oy) (cx-oy,cy-ox) (cx+ox,cy-oy) (cx+oy,cy-ox)
//   Point visible: plot_valid=1; x, y, colour held stable until plot_ready. Advance oct on valid&&ready.
//   Point clipped: plot_valid=0 for 1 cycle; advance without waiting.
//   After oct=7 advances -> UPDATE.
//   UPDATE: 1 cycle; oy+=1; if crit<=0: crit+=2*oy+1; else ox-=1, crit+=2*(oy-ox)+1.
//    Both expressions use the updated oy and ox.
//    If new oy<=new ox: oct=0 -> PLOT; else -> DONE.
//   DONE: done=1, busy=1 for 1 cycle -> IDLE.
//  Arithmetic and clipping:
//   Point sums are computed signed at max(X_W,Y_W,R_W)+2 bits.
//   Clip when a sum is <0, x>XMAX, or y>YMAX; no wrap-around ever reaches x/y.
//   crit is signed, R_W+3 bits, and cannot overflow for any radius.
//  Duplicate points (oy=0, ox=oy, or radius=0) are emitted as-is; no deduplication.
//  Latency with ready held high and no clipping:
//   start sampled at edge 0; INIT in cycle 1; first pixel valid in cycle 2.
//   Each iteration takes 8 PLOT cycles + 1 UPDATE cycle; done follows the final UPDATE.
//  Changes to the input operands while busy have no effect.
//  plot_ready while plot_valid=0 is ignored.
// TESTING
//  1. Reset, centre(30,40), r=0, ready=1: 8 pixels at (30,40); plot_valid cycles 2-9;
//     UPDATE in cycle 10; done in cycle 11; busy=0 in cycle 12.
//  2. Centre(80,40), r=1, ready=1: 16 pixels, 2 iterations. Iteration 1 is
//     (81,40)(80,41)(79,40)(80,41)(79,40)(80,39)(81,40)(80,39);
//     then crit=3, ox=1, oy=1; finish at crit=8.
//  3. Centre(5,5), r=20: every pixel with a negative coordinate is suppressed.
//     Emitted pixels match a software model of the midpoint algorithm with clipping; no x>159, no y>119.
//  4. r=20 with plot_ready toggled pseudo-randomly: x, y, colour stay stable while valid && !ready.
//     Pixel sequence is identical to the ready=1 run.
//  5. start pulsed while busy with a different radius: ignored; output is unchanged from a single-start run.
//  6. reset asserted mid-PLOT on circle r=20: all outputs 0 next cycle, state IDLE.
//     A new start after release draws correctly from INIT.

Source files
------------

// File: rtl/circle_engine.sv
// Midpoint-circle rasteriser: accepts one circle per start and streams its clipped
// 8-way symmetric outline pixels to a valid/ready sink.
module circle_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int XMAX     = 159,
  parameter int YMAX     = 119
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [R_W-1:0]      radius,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                busy,
  output logic                done,
  output logic                plot_valid,
  input  logic                plot_ready,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  // state  | meaning
  // IDLE   | waiting for start; operands latched on acceptance
  // INIT   | load ox=radius, oy=0, crit=1-radius, oct=0
  // PLOT   | present octant point oct; advance on handshake or clip
  // UPDATE | midpoint step; loop to PLOT or finish
  // DONE   | one-cycle done pulse

  localparam int M1  = (X_W > Y_W) ? X_W : Y_W;
  localparam int S_W = ((M1 > R_W) ? M1 : R_W) + 2;
  localparam int O_W = R_W + 2;
  localparam int C_W = R_W + 3;
  localparam logic signed [S_W-1:0] XLIM = S_W'(XMAX);
  localparam logic signed [S_W-1:0] YLIM = S_W'(YMAX);

  typedef enum logic [2:0] {IDLE, INIT, PLOT, UPDATE, DONE} state_t;

  state_t                     state, state_n;
  logic [X_W-1:0]             cx;
  logic [Y_W-1:0]             cy;
  logic [R_W-1:0]             rad;
  logic [COLOUR_W-1:0]        col;
  logic signed [O_W-1:0]      ox, oy, ox_n, oy_n;
  logic signed [C_W-1:0]      crit, crit_n;
  logic [2:0]                 oct;
  logic signed [S_W-1:0]      sx, sy, dx, dy, px, py;
  logic                       visible, advance, crit_le0;

  // Point selection: odd octants swap ox/oy; octants 2-5 negate x, 4-7 negate y.
  always_comb begin
    sx = $signed({{(S_W-X_W){1'b0}}, cx});
    sy = $signed({{(S_W-Y_W){1'b0}}, cy});
    dx = oct[0] ? S_W'(oy) : S_W'(ox);
    dy = oct[0] ? S_W'(ox) : S_W'(oy);
    px = (oct[2] ^ oct[1]) ? sx - dx : sx + dx;
    py = oct[2] ? sy - dy : sy + dy;
    visible = !px[S_W-1] && !py[S_W-1] && (px <= XLIM) && (py <= YLIM);
  end

  assign plot_valid = (state == PLOT) && visible;
  assign advance    = (state == PLOT) && (!visible || plot_ready);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign x          = plot_valid ? px[X_W-1:0] : '0;
  assign y          = plot_valid ? py[Y_W-1:0] : '0;
  assign colour     = col;

  always_comb begin
    crit_le0 = crit[C_W-1] || (crit == '0);
    oy_n     = oy + O_W'(1);
    ox_n     = crit_le0 ? ox : ox - O_W'(1);
    crit_n   = crit_le0 ? crit + (C_W'(oy_n) <<< 1) + C_W'(1)
                        : crit + (C_W'(oy_n - ox_n) <<< 1) + C_W'(1);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = INIT;
      INIT:    state_n = PLOT;
      PLOT:    if (advance && oct == 3'd7) state_n = UPDATE;
      UPDATE:  state_n = (oy_n <= ox_n) ? PLOT : DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cx   <= '0;
      cy   <= '0;
      rad  <= '0;
      col  <= '0;
      ox   <= '0;
      oy   <= '0;
      crit <= '0;
      oct  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cx  <= centre_x;
          cy  <= centre_y;
          rad <= radius;
          col <= colour_in;
        end
        INIT: begin
          ox   <= O_W'(rad);
          oy   <= '0;
          crit <= C_W'(1) - $signed(C_W'(rad));
          oct  <= '0;
        end
        PLOT: if (advance) oct <= oct + 3'd1;
        UPDATE: begin
          ox   <= ox_n;
          oy   <= oy_n;
          crit <= crit_n;
          oct  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
